// File: rtl/i2c_slave_pkg.sv
// Shared I2C definitions: FSM state encoding (common with the master for waveform debug),
// acknowledge levels and the position of the R/W bit in the address byte.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddr    = 3'd1,
        StAddrAck = 3'd2,
        StWrByte  = 3'd3,
        StWrAck   = 3'd4,
        StRdByte  = 3'd5,
        StRdAck   = 3'd6
    } i2c_state_e;

    localparam logic        Ack   = 1'b0;
    localparam logic        Nack  = 1'b1;
    localparam int unsigned RwBit = 0;

endpackage

// File: rtl/i2c_pin_filter.sv
// Two-flop synchronizer plus glitch filter for one bus pin; emits the accepted level and
// one-clk rise/fall strobes aligned with the level change.
module i2c_pin_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, fall_q;

    // A new level is accepted once FILTER_LEN consecutive samples disagree with the old one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// Fixed-address I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// byte receive with ACK and byte transmit on open-drain SDA. Never drives SCL.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       scl_i,
    inout  wire        sda_io,
    input  logic [7:0] tx_data_i,
    output logic       rd_req_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .pin_i   (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .pin_i   (sda_io),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       last_q, last_d;
    logic       rw_q, rw_d;
    logic       sda_low_q, sda_low_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_req_q, rd_req_d;

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        rw_d       = rw_q;
        sda_low_d  = sda_low_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;

        if (start_det) begin
            state_d   = StAddr;
            bitcnt_d  = 3'd7;
            last_d    = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StWrByte: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_lvl};
                        // last_q marks that bit 0 is in; the following fall closes the byte.
                        if (bitcnt_q == 3'd0) last_d = 1'b1;
                        else                  bitcnt_d = bitcnt_q - 3'd1;
                    end else if (scl_fall && last_q) begin
                        last_d = 1'b0;
                        if (state_q == StWrByte) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            sda_low_d  = 1'b1;
                            state_d    = StWrAck;
                        end else if (shreg_q[7:1] == SLAVE_ADDR) begin
                            rw_d      = shreg_q[RwBit];
                            sda_low_d = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = StAddrAck;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = StIdle;
                        end
                    end
                end
                StAddrAck, StRdAck: begin
                    if (scl_rise) begin
                        if (state_q == StAddrAck) begin
                            rd_req_d = rw_q;
                        end else if (sda_lvl == Ack) begin
                            rd_req_d = 1'b1;
                        end else begin
                            busy_d    = 1'b0;
                            sda_low_d = 1'b0;
                            state_d   = StIdle;
                        end
                    end else if (scl_fall) begin
                        bitcnt_d = 3'd7;
                        if (state_q == StAddrAck && !rw_q) begin
                            sda_low_d = 1'b0;
                            state_d   = StWrByte;
                        end else begin
                            shreg_d   = tx_data_i;
                            sda_low_d = ~tx_data_i[7];
                            state_d   = StRdByte;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bitcnt_d  = 3'd7;
                        state_d   = StWrByte;
                    end
                end
                StRdByte: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_low_d = 1'b0;
                            state_d   = StRdAck;
                        end else begin
                            bitcnt_d  = bitcnt_q - 3'd1;
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_low_d = ~shreg_q[6];
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bitcnt_q   <= 3'd7;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            rw_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            rw_q       <= rw_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rd_req_q   <= rd_req_d;
        end
    end

    assign sda_io     = sda_low_q ? 1'b0 : 1'bz;
    assign rd_req_o   = rd_req_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master, a byte-level transaction model and
// monitors for the local-side strobes.
module tb_i2c_slave;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       scl;
    logic       m_sda_oe;
    logic [7:0] tx_data_i;
    logic       rd_req_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;
    wire        sda_bus;

    assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave #(.SLAVE_ADDR(7'h42), .FILTER_LEN(3)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .scl_i      (scl),
        .sda_io     (sda_bus),
        .tx_data_i  (tx_data_i),
        .rd_req_o   (rd_req_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];
    int rd_cnt = 0, rxv_cycles = 0, rxv_pulses = 0, overlap = 0;
    logic rxv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Local-logic side: hand out the next queued byte on each read request.
    always @(negedge clk_i) begin
        if (rd_req_o) begin
            rd_cnt++;
            if (tx_q.size() > 0) tx_data_i = tx_q.pop_front();
        end
        if (rx_valid_o) begin
            rxv_cycles++;
            rx_q.push_back(rx_data_o);
        end
        if (rx_valid_o && !rxv_prev) rxv_pulses++;
        if (rx_valid_o && rd_req_o) overlap++;
        rxv_prev = rx_valid_o;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk_i);
    endtask

    task automatic bus_bit(input logic b, input logic glitch, output logic got);
        m_sda_oe = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        if (glitch) begin
            scl = 1'b0;
            @(negedge clk_i);
            scl = 1'b1;
        end
        got = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_oe = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_oe = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == glitch_bit), dummy);
        bus_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, 1'b0, b[i]);
        bus_bit(mack, 1'b0, dummy);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_rx.size());
        while (rx_q.size() > 0 && exp_rx.size() > 0) check(tag, rx_q.pop_front(), exp_rx.pop_front());
        rx_q.delete();
        exp_rx.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        logic       dummy;
        int         rd0;

        reset_i   = 1'b1;
        scl       = 1'b1;
        m_sda_oe  = 1'b0;
        tx_data_i = 8'h00;
        repeat (4) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (10) @(negedge clk_i);

        check("reset_rx_data", rx_data_o, 8'h00);
        check("reset_rx_valid", rx_valid_o, 1'b0);
        check("reset_rd_req", rd_req_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_sda", sda_bus, 1'b1);

        // Simple write
        bus_start();
        write_byte(8'h84, -1, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy_after_addr", busy_o, 1'b1);
        write_byte(8'hA5, -1, ack);
        check("wr_data_ack", ack, 1'b0);
        check("wr_rx_data", rx_data_o, 8'hA5);
        check("wr_busy_before_stop", busy_o, 1'b1);
        bus_stop();
        check("wr_busy_after_stop", busy_o, 1'b0);
        exp_rx.push_back(8'hA5);
        compare_rx("wr_rx");

        // Wrong address
        bus_start();
        write_byte(8'h86, -1, ack);
        check("bad_addr_nack", ack, 1'b1);
        check("bad_busy", busy_o, 1'b0);
        write_byte(8'h11, -1, ack);
        check("bad_data_nack", ack, 1'b1);
        bus_stop();
        compare_rx("bad_rx");

        // Read two bytes, master NACKs the second
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        rd0 = rd_cnt;
        bus_start();
        write_byte(8'h85, -1, ack);
        check("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, b);
        check("rd_byte0", b, 8'h3C);
        read_byte(1'b1, b);
        check("rd_byte1", b, 8'hC3);
        check("rd_busy_after_nack", busy_o, 1'b0);
        check("rd_sda_released", sda_bus, 1'b1);
        check("rd_req_count", rd_cnt - rd0, 2);
        bus_stop();

        // Write then repeated START into a read
        tx_q.push_back(8'h5A);
        bus_start();
        write_byte(8'h84, -1, ack);
        check("rs_wr_addr_ack", ack, 1'b0);
        write_byte(8'h10, -1, ack);
        check("rs_wr_data_ack", ack, 1'b0);
        check("rs_rx_data", rx_data_o, 8'h10);
        bus_start();
        write_byte(8'h85, -1, ack);
        check("rs_rd_addr_ack", ack, 1'b0);
        read_byte(1'b1, b);
        check("rs_rd_byte", b, 8'h5A);
        bus_stop();
        exp_rx.push_back(8'h10);
        compare_rx("rs_rx");

        // Reset while the slave holds the address ACK low
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'h84 >> i) & 8'h01) != 0, 1'b0, dummy);
        m_sda_oe = 1'b0;
        wait_q();
        check("rst_pre_sda_low", sda_bus, 1'b0);
        reset_i = 1'b1;
        #1;
        check("rst_sda_released", sda_bus, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_rx_valid", rx_valid_o, 1'b0);
        check("rst_rd_req", rd_req_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        wait_q();
        bus_stop();
        bus_start();
        write_byte(8'h84, -1, ack);
        check("rst_after_addr_ack", ack, 1'b0);
        write_byte(8'h77, -1, ack);
        check("rst_after_data_ack", ack, 1'b0);
        check("rst_after_rx_data", rx_data_o, 8'h77);
        bus_stop();
        exp_rx.push_back(8'h77);
        compare_rx("rst_rx");

        // SCL glitch inside a data byte
        bus_start();
        write_byte(8'h84, -1, ack);
        check("gl_addr_ack", ack, 1'b0);
        write_byte(8'hA5, 3, ack);
        check("gl_data_ack", ack, 1'b0);
        check("gl_rx_data", rx_data_o, 8'hA5);
        write_byte(8'hA5, -1, ack);
        check("gl_data2_ack", ack, 1'b0);
        bus_stop();
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'hA5);
        compare_rx("gl_rx");

        // Randomized transactions against the byte-level model
        for (int t = 0; t < 12; t++) begin
            logic       match, rw;
            logic [6:0] addr;
            int         n;
            logic [7:0] data[4];
            match = ($urandom_range(0, 3) != 0);
            addr  = 7'h42;
            if (!match) begin
                addr = 7'($urandom_range(0, 127));
                if (addr == 7'h42) addr = 7'h13;
            end
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) data[k] = 8'($urandom_range(0, 255));
            rd0 = rd_cnt;
            if (match && rw) for (int k = 0; k < n; k++) tx_q.push_back(data[k]);
            bus_start();
            write_byte({addr, rw}, -1, ack);
            check("rnd_addr_ack", ack, match ? 1'b0 : 1'b1);
            if (match && !rw) begin
                for (int k = 0; k < n; k++) begin
                    write_byte(data[k], -1, ack);
                    check("rnd_wr_ack", ack, 1'b0);
                    exp_rx.push_back(data[k]);
                end
            end else if (match) begin
                for (int k = 0; k < n; k++) begin
                    read_byte(k == n - 1, b);
                    check("rnd_rd_byte", b, data[k]);
                end
            end
            check("rnd_rd_req_count", rd_cnt - rd0, (match && rw) ? n : 0);
            bus_stop();
            check("rnd_busy_idle", busy_o, 1'b0);
            compare_rx("rnd_rx");
        end

        check("rx_valid_one_clk", rxv_cycles, rxv_pulses);
        check("rd_req_rx_valid_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Fixed-address I2C target (responder) that oversamples the SCL and SDA pins with the system clock.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- On master writes, delivers received bytes to local logic; on master reads, serializes local bytes onto SDA open-drain.
- Used as the on-chip endpoint of sensor/peripheral buses and as the loopback partner for our I2C master.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this block answers to.
- FILTER_LEN, 3, number of consecutive identical synchronized samples needed before a pin level is accepted (glitch filter, ≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock pin; no clock stretching.
- sda  inout  1  bus data pin, open-drain: drives 0 or z only.
- tx_data  input  8  byte to return on a master read; sampled at the scl falling edge that starts the byte.
- rd_req  output  1  one-clk pulse requesting the next tx_data.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- busy  output  1  high from address match until STOP, repeated START, or master NACK.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rd_req=0, busy=0, state IDLE, sda released (z), filters preset to 1 (bus idle).
- Input conditioning:
  - 2-FF synchronizer on scl and sda, then a FILTER_LEN glitch filter.
  - Edges are detected on the filtered values.
  - Worst-case latency from pin to detected edge is 2+FILTER_LEN clk.
- Bus conditions:
  - START = filtered sda falls while filtered scl is high.
  - STOP = filtered sda rises while filtered scl is high.
  - SDA changes while SCL is high are never treated as data.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- Bit counter: 3-bit, counts 7 down to 0; MSB first in both directions.
- Data sampling and driving:
  - Sample sda on the scl rising edge.
  - Change the driven sda only on the scl falling edge.
- IDLE: wait for START.
- START or repeated START in any state → ADDR, counter=7, sda released.
- ADDR:
  - Shift in 8 bits. At the falling scl after bit 0:
    - Address match → drive sda low (ACK), busy=1, go to ADDR_ACK.
    - Mismatch → release sda, go to IDLE; ignore all traffic until the next START.
- ADDR_ACK:
  - If R/W=1, pulse rd_req on the ACK scl rising edge.
  - At the ACK falling edge:
    - W → release sda, go to WR_BYTE.
    - R → load shift register from tx_data, drive bit7 (drive low if 0, z if 1), go to RD_BYTE.
- WR_BYTE:
  - Shift in 8 bits.
  - At the falling scl after bit 0: update rx_data, pulse rx_valid, drive ACK, go to WR_ACK.
- WR_ACK: at the falling edge, release sda and return to WR_BYTE. The block ACKs every written byte.
- RD_BYTE:
  - Output bits 6..0 on successive falling edges.
  - After bit 0's falling edge, release sda and go to RD_ACK.
- RD_ACK:
  - Sample the master's ack bit at the scl rising edge.
  - 0 (ACK) → pulse rd_req in the same cycle; at the falling edge, load tx_data, drive bit7, go to RD_BYTE.
  - 1 (NACK) → busy=0, release sda, go to IDLE and wait for STOP/START.
- STOP in any state → IDLE, busy=0, sda released the same cycle it is detected, no rx_valid for a partial byte.
- Simultaneous events:
  - A START detection overrides any pending bit event.
  - rd_req and rx_valid are never both high.
- Local-logic timing: tx_data must be stable from rd_req until the next scl falling edge (≥ one quarter bus period at 100 kHz with clk ≥ 4 MHz).
- Async reset mid-transfer: sda is released immediately; the block rejoins only at the next START.
- The block never drives scl.

Decomposition:
- Shared i2c package holds:
  - state encoding constants, shared with the master for waveform-debug consistency;
  - ACK=0 / NACK=1 constants;
  - the R/W bit position.
- One sub-module, i2c_pin_filter:
  - 2-FF sync, FILTER_LEN debounce, rise/fall strobe outputs;
  - instantiated twice (scl, sda).

Test Plan:
- Write 0x84 (addr 0x42, W), then 0xA5, then STOP.
  - Required: sda low on both ACK clocks; rx_data=0xA5; rx_valid exactly one clk; busy 1 until STOP then 0.
- Address 0x86 (0x43, W), then 0x11.
  - Required: sda stays z on the ACK clock; no rx_valid; busy stays 0.
- Read 0x85 with tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK.
  - Required: bus bits 00111100 then 11000011; rd_req pulses twice; after the NACK, sda released and busy=0.
- Write 0x84 + 0x10, repeated START, read 0x85 with tx_data=0x5A.
  - Required: rx_data=0x10; address re-ACKed; 0x5A read back; no STOP required between phases.
- Assert reset for 1 clk mid-bit while sda is driven low.
  - Required: sda z that cycle; outputs at reset values; the next full write 0x84/0x77 gives rx_data=0x77.
- 1-clk-wide low glitch on scl during WR_BYTE (FILTER_LEN=3).
  - Required: no extra bit shifted; a later 0xA5 is received correctly.
